// File: rtl/l1_ahb_mtx_pkg.sv
// Shared encodings and helpers for the L1 AHB bus-matrix output-stage arbiters.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: HTRANS/HBURST encodings, arbitration-mode constants, burst_beats().
package l1_ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Beats remaining after the first (NONSEQ) beat of a fixed-length burst.
    // SINGLE and undefined-length INCR return 0, so they never pin the grant.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_burst_cnt.sv
// Beat counter that pins the arbiter grant for the remainder of a fixed-length burst.
// Latency: counter updates on the HREADYM=1 edge; load/term flags are combinational.
// Backpressure: holds all state while HREADYM=0.
// Ports: HCLK, HRESET (sync, active-high), HREADYM/HSELM/HTRANSM/HBURSTM of the output
//        address phase; burst_hold (registered), burst_load and burst_term (this cycle).
module l1_ahb_mtx_burst_cnt
    import l1_ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       burst_hold,
    output logic       burst_load,
    output logic       burst_term
);

    logic [3:0] beats_left;

    assign burst_hold = (beats_left != 4'd0);
    assign burst_load = HSELM && (HTRANSM == HTRANS_NONSEQ) && (burst_beats(HBURSTM) != 4'd0);
    // A new address phase (IDLE/NONSEQ) while beats remain means the burst was cut short.
    assign burst_term = burst_hold &&
                        ((HTRANSM == HTRANS_IDLE) || (HTRANSM == HTRANS_NONSEQ));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beats_left <= 4'd0;
        end else if (HREADYM) begin
            // A NONSEQ that starts a new fixed burst takes precedence over clearing the old one.
            if (burst_load) begin
                beats_left <= burst_beats(HBURSTM);
            end else if (burst_term) begin
                beats_left <= 4'd0;
            end else if ((HTRANSM == HTRANS_SEQ) && burst_hold) begin
                beats_left <= beats_left - 4'd1;
            end
        end
    end

endmodule

// File: rtl/l1_ahb_mtx_arb_param.sv
// Output-stage arbiter choosing which of NUM_PORTS input stages drives one slave port.
// Latency: one cycle; the decision is registered on the HREADYM=1 edge.
// Backpressure: all state holds while HREADYM=0. Optional macro L1_AHB_ARB_BURST_HOLD_EN.
// Ports: HCLK, HRESET (sync, active-high), req_port, HREADYM/HSELM/HTRANSM/HBURSTM/HMASTLOCKM;
//        outputs addr_in_port (encoded), grant (one-hot), no_port, burst_hold.
module l1_ahb_mtx_arb_param
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ARB_MODE  = 0,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 no_port,
    output logic                 burst_hold
);

    logic [PORT_W-1:0]    sel_q, sel_d;
    logic                 no_port_q, no_port_d;
    logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] sel_oh;
    logic [NUM_PORTS-1:0] cand;
    logic [PORT_W-1:0]    win;
    logic                 found;
    logic                 cur_active;
    logic                 pin;

`ifdef L1_AHB_ARB_BURST_HOLD_EN
    logic burst_load;
    logic burst_term;

    l1_ahb_mtx_burst_cnt u_burst_cnt (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HREADYM    (HREADYM),
        .HSELM      (HSELM),
        .HTRANSM    (HTRANSM),
        .HBURSTM    (HBURSTM),
        .burst_hold (burst_hold),
        .burst_load (burst_load),
        .burst_term (burst_term)
    );

    // The NONSEQ that opens a fixed burst already pins the grant, otherwise the
    // owner would lose the bus before its first SEQ beat reaches the slave.
    assign pin = (burst_hold && !burst_term) || burst_load;
`else
    logic unused_hburst;

    assign unused_hburst = ^HBURSTM;
    assign burst_hold    = 1'b0;
    assign pin           = 1'b0;
`endif

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    assign cur_active = HSELM && (HTRANSM != HTRANS_IDLE);
    // The current owner stays a candidate while it has an active transfer, even
    // if its input stage has dropped the request.
    assign cand = req_port | ((cur_active && !no_port_q) ? sel_oh : '0);

    always_comb begin
        win   = '0;
        found = 1'b0;
        if (ARB_MODE == ARB_RR) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && cand[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
                    found = 1'b1;
                    win   = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
                end
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    win   = PORT_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_d     = sel_q;
        no_port_d = no_port_q;
        rr_ptr_d  = rr_ptr_q;
        if (HMASTLOCKM || pin) begin
            // keep the current selection
        end else if (found) begin
            sel_d     = win;
            no_port_d = 1'b0;
            if (no_port_q || (win != sel_q)) begin
                rr_ptr_d = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
            end
        end else if (HSELM) begin
            // slave still addressed with no requester: keep the selection
        end else begin
            no_port_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q     <= '0;
            no_port_q <= 1'b1;
            rr_ptr_q  <= '0;
        end else if (HREADYM) begin
            sel_q     <= sel_d;
            no_port_q <= no_port_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign addr_in_port = sel_q;
    assign no_port      = no_port_q;
    assign grant        = no_port_q ? '0 : sel_oh;

endmodule

// File: tb/tb_l1_ahb_mtx_arb_param.sv
module tb_l1_ahb_mtx_arb_param;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;

    logic [1:0] fp_addr, rr_addr;
    logic [3:0] fp_grant, rr_grant;
    logic       fp_no_port, rr_no_port;
    logic       fp_bh, rr_bh;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef L1_AHB_ARB_BURST_HOLD_EN
    localparam bit BH_EN = 1'b1;
`else
    localparam bit BH_EN = 1'b0;
`endif

    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_WRAP8 = 3'b100;

    always #5 HCLK = ~HCLK;

    l1_ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(0)) u_fp (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(fp_addr), .grant(fp_grant), .no_port(fp_no_port), .burst_hold(fp_bh)
    );

    l1_ahb_mtx_arb_param #(.NUM_PORTS(4), .ARB_MODE(1)) u_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(rr_addr), .grant(rr_grant), .no_port(rr_no_port), .burst_hold(rr_bh)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_fp(input string tag, input int port);
        chk({tag, "_fp_addr"},  32'(fp_addr),    32'(port));
        chk({tag, "_fp_grant"}, 32'(fp_grant),   32'(1) << port);
        chk({tag, "_fp_nop"},   32'(fp_no_port), 32'd0);
    endtask

    task automatic chk_rr(input string tag, input int port);
        chk({tag, "_rr_addr"},  32'(rr_addr),    32'(port));
        chk({tag, "_rr_grant"}, 32'(rr_grant),   32'(1) << port);
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked at the same point.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_bus(input logic sel, input logic [1:0] tr, input logic [2:0] bu);
        HSELM   = sel;
        HTRANSM = tr;
        HBURSTM = bu;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        req_port   = 4'b1111;
        HREADYM    = 1'b1;
        HMASTLOCKM = 1'b0;
        set_bus(1'b0, T_IDLE, B_SINGLE);
        step();
        step();
        HRESET = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        do_reset();
        chk("rst_fp_nop",   32'(fp_no_port), 32'd1);
        chk("rst_fp_grant", 32'(fp_grant),   32'd0);
        chk("rst_fp_addr",  32'(fp_addr),    32'd0);
        chk("rst_rr_nop",   32'(rr_no_port), 32'd1);
        chk("rst_fp_bh",    32'(fp_bh),      32'd0);
        req_port = 4'b1111;
        step();
        chk_fp("rel", 0);

        // ---------------- fixed priority ----------------
        req_port = 4'b1100;
        step();
        chk_fp("fp_1100", 2);
        req_port = 4'b1110;
        step();
        chk_fp("fp_1110", 1);
        req_port = 4'b0001;
        HREADYM  = 1'b0;
        step();
        chk_fp("fp_stall", 1);
        HREADYM = 1'b1;
        step();
        chk_fp("fp_0001", 0);

        // ---------------- round robin ----------------
        do_reset();
        req_port = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_rr($sformatf("rr_seq%0d", k), k % 4);
        end
        chk_fp("rr_fixed_ref", 0);
        HREADYM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_rr($sformatf("rr_frz%0d", k), 0);
        end
        HREADYM = 1'b1;
        step();
        chk_rr("rr_resume", 1);

        // ---------------- INCR4 burst on port 3 ----------------
        do_reset();
        req_port = 4'b1000;
        step();
        chk_fp("b4_own", 3);
        req_port = 4'b0001;
        set_bus(1'b1, T_NONSEQ, B_INCR4);
        step();
        chk_fp("b4_beat1", BH_EN ? 3 : 0);
        chk("b4_bh1", 32'(fp_bh), 32'(BH_EN));
        set_bus(1'b1, T_SEQ, B_INCR4);
        step();
        chk_fp("b4_beat2", BH_EN ? 3 : 0);
        chk("b4_bh2", 32'(fp_bh), 32'(BH_EN));
        step();
        chk_fp("b4_beat3", BH_EN ? 3 : 0);
        chk("b4_bh3", 32'(fp_bh), 32'(BH_EN));
        step();
        chk_fp("b4_beat4", BH_EN ? 3 : 0);
        chk("b4_bh4", 32'(fp_bh), 32'd0);
        set_bus(1'b0, T_IDLE, B_SINGLE);
        step();
        chk_fp("b4_after", 0);

        // ---------------- WRAP8 early termination ----------------
        do_reset();
        req_port = 4'b0100;
        step();
        chk_fp("w8_own", 2);
        req_port = 4'b0010;
        set_bus(1'b1, T_NONSEQ, B_WRAP8);
        step();
        chk_fp("w8_beat1", BH_EN ? 2 : 1);
        set_bus(1'b1, T_SEQ, B_WRAP8);
        step();
        step();
        chk_fp("w8_beat3", BH_EN ? 2 : 1);
        chk("w8_bh3", 32'(fp_bh), 32'(BH_EN));
        set_bus(1'b1, T_IDLE, B_WRAP8);
        step();
        chk_fp("w8_term", 1);
        chk("w8_bh_term", 32'(fp_bh), 32'd0);

        // ---------------- lock, retain and no_port ----------------
        do_reset();
        req_port = 4'b0100;
        step();
        chk_fp("lk_own", 2);
        HMASTLOCKM = 1'b1;
        req_port   = 4'b0001;
        step();
        chk_fp("lk_hold1", 2);
        step();
        chk_fp("lk_hold2", 2);
        HMASTLOCKM = 1'b0;
        req_port   = 4'b0000;
        set_bus(1'b1, T_IDLE, B_SINGLE);
        step();
        chk_fp("lk_hsel_keep", 2);
        set_bus(1'b0, T_IDLE, B_SINGLE);
        step();
        chk("nop_fp_nop",   32'(fp_no_port), 32'd1);
        chk("nop_fp_grant", 32'(fp_grant),   32'd0);
        chk("nop_fp_addr",  32'(fp_addr),    32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
